// File: rtl/drive_cmd_pkg.sv
// Shared opcodes, FSM encodings and command-field bit positions for the
// motion command scheduler and the UART frame packer.
package drive_cmd_pkg;

  localparam logic [2:0] OP_STOP    = 3'd0;
  localparam logic [2:0] OP_FWD     = 3'd1;
  localparam logic [2:0] OP_TURN_L  = 3'd2;
  localparam logic [2:0] OP_TURN_R  = 3'd3;
  localparam logic [2:0] OP_UTURN   = 3'd4;
  localparam logic [2:0] OP_PLACE   = 3'd5;
  localparam logic [2:0] OP_DESTROY = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EXEC = 2'd2,
    ST_POST = 2'd3
  } state_t;

  localparam int BIT_FWD     = 0;
  localparam int BIT_BACK    = 1;
  localparam int BIT_LEFT    = 2;
  localparam int BIT_RIGHT   = 3;
  localparam int BIT_PLACE   = 4;
  localparam int BIT_DESTROY = 5;

  function automatic logic [5:0] op_pattern(input logic [2:0] op);
    logic [5:0] p;
    p = '0;
    case (op)
      OP_FWD:     p[BIT_FWD]     = 1'b1;
      OP_TURN_L:  p[BIT_LEFT]    = 1'b1;
      OP_TURN_R:  p[BIT_RIGHT]   = 1'b1;
      OP_UTURN:   p[BIT_LEFT]    = 1'b1;
      OP_PLACE:   p[BIT_PLACE]   = 1'b1;
      OP_DESTROY: p[BIT_DESTROY] = 1'b1;
      default:    p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/drive_cmd_scheduler_if.sv
// Auto-driving requester handshake: opcode in, ready/done/abort back.
interface drive_cmd_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_abort;

  modport master (output cmd_valid, output cmd_op,
                  input cmd_ready, input cmd_done, input cmd_abort);
  modport slave  (input cmd_valid, input cmd_op,
                  output cmd_ready, output cmd_done, output cmd_abort);
endinterface

// File: rtl/phase_timer.sv
// Phase timer: counts ms ticks since the last clear and pulses expire on the
// tick that completes the requested duration (a duration of 0 acts as 1).
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] duration,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last   = (duration == '0) ? '0 : duration - CNT_W'(1);
  // clear is held during the phase-entry cycle, so a tick there is not counted
  assign expire = tick & ~clear & (cnt == last);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Motion command field owner: manual passthrough or timed auto manoeuvres
// sequenced as pre-stop / execute / post-stop with a front-detector abort.
//
// state | meaning
// IDLE  | no manoeuvre; manual passthrough or zero field, ready in auto mode
// PRE   | stopped for STOP_MS before the manoeuvre
// EXEC  | op pattern driven for the op duration
// POST  | stopped for STOP_MS after the manoeuvre (or after a safety abort)
module drive_cmd_scheduler
  import drive_cmd_pkg::*;
#(
  parameter int TURN_MS  = 900,
  parameter int UTURN_MS = 1800,
  parameter int FWD_MS   = 300,
  parameter int STOP_MS  = 100,
  parameter int PULSE_MS = 50,
  parameter int CNT_W    = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  tick_ms,
  input  logic                  mode_auto,
  input  logic [5:0]            man_cmd,
  drive_cmd_scheduler_if.slave  cmd_bus,
  input  logic                  front_det,
  output logic [5:0]            drive_out,
  output logic                  busy,
  output logic [1:0]            state_o
);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic             entry_q;
  logic             front_abort_q;
  logic [CNT_W-1:0] dur;
  logic             expire;
  logic             accept, mode_drop, front_hit;
  logic [5:0]       drive_nxt;
  logic             done_nxt, abort_nxt;

  assign cmd_bus.cmd_ready = mode_auto & (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign state_o   = state;
  assign accept    = cmd_bus.cmd_valid & cmd_bus.cmd_ready;
  assign mode_drop = ~mode_auto & (state != ST_IDLE);
  assign front_hit = (state == ST_EXEC) & (op_q == OP_FWD) & front_det;

  always_comb begin
    dur = CNT_W'(STOP_MS);
    if (state == ST_EXEC) begin
      case (op_q)
        OP_STOP:              dur = CNT_W'(STOP_MS);
        OP_FWD:               dur = CNT_W'(FWD_MS);
        OP_TURN_L, OP_TURN_R: dur = CNT_W'(TURN_MS);
        OP_UTURN:             dur = CNT_W'(UTURN_MS);
        OP_PLACE, OP_DESTROY: dur = CNT_W'(PULSE_MS);
        default:              dur = '0;
      endcase
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (entry_q),
    .tick     (tick_ms),
    .duration (dur),
    .expire   (expire)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      op_q          <= OP_STOP;
      entry_q       <= 1'b0;
      front_abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      entry_q <= (state_nxt != state);
      if (accept) begin
        op_q          <= cmd_bus.cmd_op;
        front_abort_q <= 1'b0;
      end else if (front_hit && !mode_drop) begin
        front_abort_q <= 1'b1;
      end
    end
  end

  // Priority in every busy state: mode drop, then safety abort, then phase end
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && cmd_bus.cmd_op != OP_RSVD) state_nxt = ST_PRE;
      ST_PRE:  if (mode_drop) state_nxt = ST_IDLE;
               else if (expire) state_nxt = ST_EXEC;
      ST_EXEC: if (mode_drop) state_nxt = ST_IDLE;
               else if (front_hit || expire) state_nxt = ST_POST;
      ST_POST: if (mode_drop) state_nxt = ST_IDLE;
               else if (expire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    drive_nxt = '0;
    if (!mode_auto)                drive_nxt = man_cmd;
    else if (state_nxt == ST_EXEC) drive_nxt = op_pattern(op_q);
    done_nxt  = ((state == ST_POST) & expire & ~mode_drop & ~front_abort_q)
              | (accept & (cmd_bus.cmd_op == OP_RSVD));
    abort_nxt = mode_drop | front_hit;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      drive_out         <= '0;
      cmd_bus.cmd_done  <= 1'b0;
      cmd_bus.cmd_abort <= 1'b0;
    end else begin
      drive_out         <= drive_nxt;
      cmd_bus.cmd_done  <= done_nxt;
      cmd_bus.cmd_abort <= abort_nxt;
    end
  end

endmodule

// File: doc/drive_cmd_scheduler.md
Name: drive_cmd_scheduler

Overview:
Owns the 6-bit motion command field of the UART frame to the car simulator: {destroy, place, right, left, back, fwd}. Arbitrates between the manual driving path and an auto-driving requester. Auto commands are timed manoeuvres issued over a valid/ready handshake. Each is sequenced as pre-stop, execute, post-stop, with a front-detector safety abort.

Parameters:
TURN_MS, 900, execute duration of a 90-degree turn (ms ticks)
UTURN_MS, 1800, execute duration of a U-turn
FWD_MS, 300, execute duration of one forward step
STOP_MS, 100, duration of each pre-stop and post-stop phase, and of the STOP op's execute phase
PULSE_MS, 50, execute duration of a place/destroy barrier pulse
CNT_W, 16, width of the phase counter

Ports:
sys_clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-low
tick_ms  in  1  one-cycle pulse every 1 ms (from the clock divider)
mode_auto  in  1  1 = auto requester owns the command field; 0 = manual
man_cmd  in  6  manual command {destroy,place,right,left,back,fwd}
cmd_valid  in  1  auto command valid
cmd_op  in  3  auto opcode
cmd_ready  out  1  scheduler can accept an opcode
cmd_done  out  1  one-cycle pulse when an op completes normally
cmd_abort  out  1  one-cycle pulse when an op is terminated early
front_det  in  1  front detector from the simulator
drive_out  out  6  registered command field to the UART frame
busy  out  1  state != IDLE
state_o  out  2  current FSM state, for LEDs/seg

Behaviour:
- Clock and reset: single clock sys_clk; rst is asynchronous, active-low.
- Reset values: state=IDLE; drive_out=0; cmd_done=0; cmd_abort=0; counter=0; latched op=STOP. All outputs are registered except cmd_ready, busy and state_o, which decode directly from state.
- Opcodes:
  - 0 STOP: execute = all zero for STOP_MS.
  - 1 FWD: fwd=1 for FWD_MS.
  - 2 TURN_L: left=1 for TURN_MS.
  - 3 TURN_R: right=1 for TURN_MS.
  - 4 UTURN: left=1 for UTURN_MS.
  - 5 PLACE: place=1 for PULSE_MS.
  - 6 DESTROY: destroy=1 for PULSE_MS.
  - 7: reserved.
- Ready: cmd_ready = mode_auto & (state==IDLE). A command is accepted on a cycle with cmd_valid & cmd_ready; cmd_op is latched on that edge.
- States:
  - IDLE -> PRE on accept. In PRE, drive_out=0.
  - PRE -> EXEC after STOP_MS ticks. drive_out takes the op pattern on the first EXEC cycle.
  - EXEC -> POST after the op duration. drive_out=0 in POST.
  - POST -> IDLE after STOP_MS ticks. cmd_done pulses on the POST->IDLE transition cycle, registered, so it is visible in the first IDLE cycle.
- Reserved op 7: accepted; IDLE -> IDLE directly; cmd_done pulses the next cycle; no motion.
- Phase timing:
  - The counter clears on every state change and increments only on tick_ms.
  - A phase of duration D ends on the tick at which counter==D-1. D=0 is treated as 1.
  - A phase therefore lasts D ticks, measured from entry.
  - A tick arriving in the same cycle as phase entry is not counted.
- Safety abort: in EXEC with op FWD, front_det=1 causes the following on the next edge:
  - drive_out is forced to 0;
  - cmd_abort pulses;
  - the state moves to POST.
  - After POST completes, the state returns to IDLE with no cmd_done.
  - front_det=1 in any other state or op is ignored.
- Mode change mid-op: mode_auto falling while in PRE, EXEC or POST causes the following on the next edge:
  - state=IDLE;
  - cmd_abort pulses;
  - no cmd_done.
  - The same edge (one-cycle latency) starts driving man_cmd onto drive_out.
- Manual mode (mode_auto=0): drive_out <= man_cmd every cycle, one-cycle latency. cmd_valid is ignored.
- Simultaneous events:
  - If abort and phase end coincide, abort wins.
  - If mode drop and front_det coincide, mode drop wins: IDLE, a single cmd_abort pulse.
- Auto mode while IDLE: drive_out=0.
- Back-to-back commands: a new command can be accepted in the first IDLE cycle, the same cycle cmd_done is visible.

Decomposition:
- Package drive_cmd_pkg:
  - opcode localparams (OP_STOP..OP_RSVD);
  - state encodings IDLE=0, PRE=1, EXEC=2, POST=3;
  - bit indices of the 6-bit command field (FWD=0, BACK=1, LEFT=2, RIGHT=3, PLACE=4, DESTROY=5), shared with the top-level frame packing.
- One sub-module, phase_timer:
  - inputs: clear, tick, duration (CNT_W);
  - output: expire pulse;
  - implements the counter and the D=0 -> 1 rule.

Test Plan:
- Reset mid-EXEC of TURN_L (rst low for 3 cycles) -> drive_out=0, state_o=0, cmd_ready=1 (with mode_auto=1), no done/abort pulse.
- mode_auto=1, TURN_R accepted; TURN_MS=900, STOP_MS=100 -> right bit (bit 3) high for exactly 900 ticks, preceded and followed by 100 ticks of 0; cmd_done pulses once after 1100 ticks total; cmd_ready low throughout.
- FWD accepted; front_det=1 at tick 150 of EXEC -> drive_out=0 the next cycle, cmd_abort pulses once, POST lasts 100 ticks, then IDLE with no cmd_done.
- UTURN in EXEC; mode_auto drops; man_cmd=6'b000001 -> next cycle state=IDLE, cmd_abort=1, drive_out=6'b000001.
- Op 7, then op 5 (PLACE) presented in the cycle cmd_done is visible -> cmd_done for op 7 one cycle after accept; PLACE accepted back-to-back with no gap; place bit (bit 4) high for 50 ticks.
- mode_auto=0, cmd_valid=1 held -> cmd_ready=0, no accept; drive_out tracks man_cmd with one-cycle latency.
